// File: rtl/kernel_frame_pkg.sv
// Shared definitions for the convolution write-back path: FSM encoding and
// frame-size helpers used by the writer and the read-side controller.
package kernel_frame_pkg;

    typedef enum logic [1:0] {
        WRITE_FRAME = 2'b01,
        SEND_FRAME  = 2'b11
    } state_t;

    // Number of bits needed to represent value (pass depth-1 for an address width).
    function automatic int clogb2(input int unsigned value);
        int          bits;
        int unsigned v;
        bits = 0;
        v    = value;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    function automatic int out_w(input int image_width, input int kernel_width);
        return image_width - kernel_width + 1;
    endfunction

    function automatic int out_h(input int image_height, input int kernel_width);
        return image_height - kernel_width + 1;
    endfunction

endpackage

// File: rtl/xilinx_single_port_ram_no_change.sv
// Single-port block RAM in no-change mode: the read latch keeps its value
// during writes. LOW_LATENCY drives douta from the latch; HIGH_PERFORMANCE adds a register.
module xilinx_single_port_ram_no_change
    import kernel_frame_pkg::*;
#(
    parameter int RAM_WIDTH       = 8,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "LOW_LATENCY",
    parameter int ADDR_WIDTH      = clogb2(RAM_DEPTH - 1)
) (
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [RAM_WIDTH-1:0]  dina,
    input  logic                  clka,
    input  logic                  wea,
    input  logic                  ena,
    input  logic                  rsta,
    input  logic                  regcea,
    output logic [RAM_WIDTH-1:0]  douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    // NOTE: the storage array has no reset; frame contents survive a reset, only the output latch clears.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            ram_data <= '0;
        end else if (ena && !wea) begin
            ram_data <= mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            logic unused_regcea;
            assign unused_regcea = regcea;
            assign douta         = ram_data;
        end else begin : g_high_performance
            logic [RAM_WIDTH-1:0] douta_reg;
            always_ff @(posedge clka) begin
                if (rsta) begin
                    douta_reg <= '0;
                end else if (regcea) begin
                    douta_reg <= ram_data;
                end
            end
            assign douta = douta_reg;
        end
    endgenerate

endmodule

// File: rtl/kernel_frame_writer.sv
// Reorders column-scan kernel results into a raster-order output BRAM, then streams the frame
// out one pixel per read-request edge. Define KERNEL_FRAME_WRITER_CLAMP_EN to saturate instead of truncate.
module kernel_frame_writer
    import kernel_frame_pkg::*;
#(
    parameter int RAM_WIDTH    = 8,
    parameter int ACC_WIDTH    = 20,
    parameter int RAM_DEPTH    = 2**16,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    input  logic signed [ACC_WIDTH-1:0] i_data,
    output logic                        o_ready,
    input  logic                        i_read_valid,
    output logic [RAM_WIDTH-1:0]        o_data,
    output logic                        o_data_valid,
    output logic                        o_frame_done,
    output logic [1:0]                  o_state
);

    localparam int OUT_W   = out_w(IMAGE_WIDTH, KERNEL_WIDTH);
    localparam int OUT_H   = out_h(IMAGE_HEIGHT, KERNEL_WIDTH);
    localparam int OUT_RES = OUT_W * OUT_H;
    localparam int ADDR_W  = clogb2(RAM_DEPTH - 1);

    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] RADDR_LAST = ADDR_W'(OUT_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(OUT_W);

    state_t               state;
    state_t               state_next;
    logic                 ready_r;
    logic [ADDR_W-1:0]    row_cnt;
    logic [ADDR_W-1:0]    col_cnt;
    logic [ADDR_W-1:0]    waddr;
    logic [ADDR_W-1:0]    raddr;
    logic                 we_r;
    logic [RAM_WIDTH-1:0] wdata_r;
    logic [ADDR_W-1:0]    waddr_r;
    logic                 rv_prev;
    logic                 edge_r;
    logic                 valid_r;
    logic                 done_r;
    logic [RAM_WIDTH-1:0] pixel;
    logic [ADDR_W-1:0]    addra;

    logic accept;
    logic last_accept;
    logic rd_fire;
    logic last_read;

    assign accept      = i_valid && ready_r;
    assign last_accept = accept && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    assign rd_fire     = edge_r && (state == SEND_FRAME);
    assign last_read   = (raddr == RADDR_LAST);

`ifdef KERNEL_FRAME_WRITER_CLAMP_EN
    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << RAM_WIDTH) - 1);

    always_comb begin
        if (i_data[ACC_WIDTH-1]) begin
            pixel = '0;
        end else if (i_data > PIX_MAX) begin
            pixel = '1;
        end else begin
            pixel = i_data[RAM_WIDTH-1:0];
        end
    end
`else
    logic unused_msbs;
    assign unused_msbs = ^i_data[ACC_WIDTH-1:RAM_WIDTH];

    always_comb begin
        pixel = i_data[RAM_WIDTH-1:0];
    end
`endif

    always_comb begin
        // NOTE: defaults first, so no branch of the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            WRITE_FRAME: if (last_accept)          state_next = SEND_FRAME;
            SEND_FRAME:  if (rd_fire && last_read) state_next = WRITE_FRAME;
            default:                               state_next = WRITE_FRAME;
        endcase
    end

    // NOTE: all state below is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= WRITE_FRAME;
            ready_r <= 1'b0;
            row_cnt <= '0;
            col_cnt <= '0;
            waddr   <= '0;
            raddr   <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            waddr_r <= '0;
            rv_prev <= 1'b0;
            edge_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_r <= (state_next == WRITE_FRAME);
            rv_prev <= i_read_valid;
            // Edges sampled outside SEND_FRAME, including the transition cycle, are dropped here.
            edge_r  <= i_read_valid && !rv_prev && (state == SEND_FRAME);
            we_r    <= accept;
            valid_r <= rd_fire;
            done_r  <= rd_fire && last_read;

            if (accept) begin
                wdata_r <= pixel;
                waddr_r <= waddr;
                if (last_accept) begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                    waddr   <= '0;
                end else if (row_cnt == ROW_LAST) begin
                    row_cnt <= '0;
                    col_cnt <= col_cnt + 1'b1;
                    waddr   <= col_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                    waddr   <= waddr + ROW_STEP;
                end
            end

            if (rd_fire) begin
                raddr <= last_read ? '0 : raddr + 1'b1;
            end
        end
    end

    // The final write lands in the first SEND_FRAME cycle, so a pending strobe keeps the write address.
    assign addra = ((state == SEND_FRAME) && !we_r) ? raddr : waddr_r;

    xilinx_single_port_ram_no_change #(
        .RAM_WIDTH       (RAM_WIDTH),
        .RAM_DEPTH       (RAM_DEPTH),
        .RAM_PERFORMANCE ("LOW_LATENCY"),
        .ADDR_WIDTH      (ADDR_W)
    ) u_ram (
        .addra  (addra),
        .dina   (wdata_r),
        .clka   (clk),
        .wea    (we_r),
        .ena    (we_r || rd_fire),
        .rsta   (!reset),
        .regcea (1'b1),
        .douta  (o_data)
    );

    assign o_ready      = ready_r;
    assign o_data_valid = valid_r;
    assign o_frame_done = done_r;
    assign o_state      = state;

endmodule

// File: doc/kernel_frame_writer.md
# kernel_frame_writer

Write-back side of the convolution pipeline. Accepts kernel results in the same column-scan order used to read pixels out of the frame BRAM, and writes each result at its raster address in an output BRAM sized for the valid-convolution image. Then streams the finished frame out in raster order, one pixel per rising edge of a read request. The stream goes toward the microblaze, and the block then re-arms for the next frame.

## Interface
Parameters:
- RAM_WIDTH, 8: stored pixel width.
- ACC_WIDTH, 20: width of incoming signed kernel result.
- RAM_DEPTH, 2**16: output BRAM entries.
- IMAGE_WIDTH, 10: input image width.
- IMAGE_HEIGHT, 10: input image height.
- KERNEL_WIDTH, 3: square kernel size.

Derived values:
- OUT_W = IMAGE_WIDTH-KERNEL_WIDTH+1.
- OUT_H = IMAGE_HEIGHT-KERNEL_WIDTH+1.
- OUT_RES = OUT_W*OUT_H.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- i_valid  in  1  i_data holds a kernel result.
- i_data  in  ACC_WIDTH  signed kernel result.
- o_ready  out  1  block accepts results (WRITE_FRAME).
- i_read_valid  in  1  read request; each rising edge fetches one pixel.
- o_data  out  RAM_WIDTH  pixel read from output BRAM.
- o_data_valid  out  1  one-cycle pulse, o_data is new.
- o_frame_done  out  1  one-cycle pulse with the last pixel of a frame.
- o_state  out  2  current state, for debug.

## Operation
States:
- WRITE_FRAME = 2'b01 (reset state).
- SEND_FRAME = 2'b11.
- Any other encoding goes to WRITE_FRAME.

WRITE_FRAME:
- o_ready=1.
- A result is accepted on each cycle where i_valid=1 and o_ready=1.
- Input order is column-major: row 0..OUT_H-1 of column 0, then column 1, and so on.
- Counters row_cnt and col_cnt track position. Write address is updated incrementally with no multiplier:
  - after an accept, addr += OUT_W;
  - on row wrap (row_cnt==OUT_H-1), row_cnt=0, col_cnt+=1, addr=col_cnt+1.
- BRAM write strobe and data are registered, so the write happens one cycle after the accept.
- Accept at (row OUT_H-1, col OUT_W-1) is the last. The next cycle the state becomes SEND_FRAME, o_ready=0, and the read address is 0.
- i_valid with o_ready=0 is ignored.

SEND_FRAME:
- A registered edge detector fires when the previous sample of i_read_valid is 0 and the current sample is 1.
- Each edge reads the BRAM at raddr, then raddr+=1.
- Holding i_read_valid high yields exactly one pixel.
- The read with raddr==OUT_RES-1 asserts o_frame_done together with its o_data_valid. The state then returns to WRITE_FRAME, and all counters and addresses clear.

Edge-detector behaviour by state:
- It runs in all states.
- Edges seen in WRITE_FRAME are discarded.
- An edge in the same cycle as the WRITE_FRAME→SEND_FRAME transition is discarded.

Reset (reset=0, any state):
- State goes to WRITE_FRAME; counters, addresses and the edge detector clear.
- Outputs: o_ready=0 while reset=0, then 1 on the first cycle after release.
- o_data=0, o_data_valid=0, o_frame_done=0, o_state=2'b01.
- BRAM contents are not cleared.

## Timing
- Write: accept at cycle n → BRAM written at n+1.
- Read: edge sampled at n → edge register high at n+1 → o_data updated and o_data_valid=1 at n+2.
- o_data holds its value until the next read.
- Minimum spacing between reads is 2 cycles, set by the low/high toggle of i_read_valid.
- Throughput: one result accepted per cycle.

## Configuration
- KERNEL_FRAME_WRITER_CLAMP_EN defined: signed i_data is saturated to [0, 2**RAM_WIDTH-1] before storage. Negative values become 0; values above the maximum become 255 for 8 bits.
- Not defined: i_data[RAM_WIDTH-1:0] is stored as-is (truncation).

## Structure
- Shared package kernel_frame_pkg contains:
  - state localparams WRITE_FRAME and SEND_FRAME;
  - clogb2 function;
  - OUT_W/OUT_H derivation helpers.
- The read-side controller uses the same package.
- Sub-module: xilinx_single_port_ram_no_change with RAM_PERFORMANCE "LOW_LATENCY" and regcea tied high.
- The write and read addresses are muxed onto addra by state.
- Top-level RTL holds the FSM, counters, edge detector and clamp.

## Test plan
All scenarios use 10x10 input, K=3, so OUT_W=OUT_H=8 and OUT_RES=64.
- Reset: hold reset=0 for 3 cycles → o_ready=0, o_data=0, o_data_valid=0, o_frame_done=0, o_state=01. After release → o_ready=1.
- Scan reorder: write 64 results with value n at input index n (column-major) → sends 0..63 return (k%8)*8+k/8. Send 1 returns 8, send 63 returns 63 with o_frame_done=1. Then o_ready=1.
- Handshake gaps: random i_valid gaps; extra i_valid pulses after the 64th accept while o_ready=0 → those pulses are not stored, and the output matches the previous scenario.
- Held read: i_read_valid high for 10 cycles → exactly one o_data_valid, 2 cycles after the rising edge.
- Clamp with KERNEL_FRAME_WRITER_CLAMP_EN: inputs -5 and 300 → 0 and 255. Without the macro: 300 → 44, and -5 → 251.
- Reset mid-write: reset after 30 accepts, then 64 fresh writes → readback matches the fresh data only, and the first read returns the first fresh value.
